// File: rtl/word_deserializer_if.sv
// Bus bundle for word_deserializer: serial valid/ready link in, parallel word valid/ready out.
interface word_deserializer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             ser_in;
    logic             ser_valid;
    logic             ser_ready;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic             parity_err;

    // Producer of serial bits and consumer of words (the environment).
    modport master (
        output ser_in, ser_valid, word_ready,
        input  ser_ready, word_out, word_valid, parity_err
    );

    // The deserializer itself.
    modport slave (
        input  ser_in, ser_valid, word_ready,
        output ser_ready, word_out, word_valid, parity_err
    );
endinterface

// File: rtl/word_deserializer.sv
// Serial-to-parallel word receiver with a registered valid/ready word output.
// Define WORD_DESER_PARITY_EN to append an even-parity bit to every frame.
module word_deserializer #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic               clk,
    input logic               rst,
    word_deserializer_if.slave bus
);
`ifdef WORD_DESER_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif
    localparam int unsigned       CNT_W    = $clog2(FRAME + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LAST
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
`ifdef WORD_DESER_PARITY_EN
    logic             perr_q, perr_d;
`endif

    logic             ser_ready_c;
    logic             accept;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        // Only the completing bit may stall, and only while the held word is not draining.
        ser_ready_c = !((state_q == ST_LAST) && valid_q && !bus.word_ready);
        accept      = bus.ser_valid && ser_ready_c;
        cnt_inc     = cnt_q + CNT_W'(1);
        if (MSB_FIRST) begin
            shifted = {shift_q[WIDTH-2:0], bus.ser_in};
        end else begin
            shifted = {bus.ser_in, shift_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        word_d  = word_q;
        valid_d = valid_q;
`ifdef WORD_DESER_PARITY_EN
        perr_d  = perr_q;
`endif

        if (valid_q && bus.word_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                ST_IDLE, ST_SHIFT: begin
                    shift_d = shifted;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == LAST_CNT) ? ST_LAST : ST_SHIFT;
                end
                ST_LAST: begin
`ifdef WORD_DESER_PARITY_EN
                    // The completing bit is parity: data is already fully shifted in.
                    word_d  = shift_q;
                    perr_d  = (^shift_q) ^ bus.ser_in;
`else
                    word_d  = shifted;
                    shift_d = shifted;
`endif
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
`ifdef WORD_DESER_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            valid_q <= valid_d;
`ifdef WORD_DESER_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign bus.ser_ready  = ser_ready_c;
    assign bus.word_out   = word_q;
    assign bus.word_valid = valid_q;
`ifdef WORD_DESER_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_word_deserializer.sv
// Directed bench for word_deserializer: an MSB-first and an LSB-first instance share one stimulus port.
module tb_word_deserializer;
`ifdef WORD_DESER_PARITY_EN
    localparam int unsigned FRAME = 33;
`else
    localparam int unsigned FRAME = 32;
`endif

    logic        clk;
    logic        rst;
    logic        sel;          // 0: MSB-first instance, 1: LSB-first instance
    logic        ser_in;
    logic        ser_valid;
    logic        word_ready;
    logic        ser_ready;
    logic [31:0] word_out;
    logic        word_valid;
    logic        parity_err;

    int unsigned n_cmp;
    int unsigned n_err;

    word_deserializer_if #(.WIDTH(32)) if_m ();
    word_deserializer_if #(.WIDTH(32)) if_l ();

    word_deserializer #(.WIDTH(32), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(if_m));
    word_deserializer #(.WIDTH(32), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(if_l));

    assign if_m.ser_in     = ser_in;
    assign if_m.ser_valid  = ser_valid && !sel;
    assign if_m.word_ready = word_ready;
    assign if_l.ser_in     = ser_in;
    assign if_l.ser_valid  = ser_valid && sel;
    assign if_l.word_ready = word_ready;

    assign ser_ready  = sel ? if_l.ser_ready  : if_m.ser_ready;
    assign word_out   = sel ? if_l.word_out   : if_m.word_out;
    assign word_valid = sel ? if_l.word_valid : if_m.word_valid;
    assign parity_err = sel ? if_l.parity_err : if_m.parity_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [31:0] data;
        logic        pbit;
        logic        gaps;
        logic [31:0] exp_word;
        logic        exp_perr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [31:0] data, input logic msb,
                                       input logic pbit, input int unsigned k);
        logic [31:0] d;
        d = data;
        if (k >= 32) return pbit;
        return msb ? d[31-k] : d[k];
    endfunction

    // Called at a negedge; returns at the negedge after the bit was accepted.
    task automatic send_bit(input logic b);
        int unsigned n;
        n         = 0;
        ser_in    = b;
        ser_valid = 1'b1;
        #1;
        while (!ser_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!ser_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_bit_timeout: got ser_ready=0 required 1");
        end
        @(posedge clk);
        @(negedge clk);
        ser_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] data, input logic msb, input logic pbit,
                             input logic gaps, input int unsigned nbits);
        for (int unsigned k = 0; k < nbits; k++) begin
            send_bit(frame_bit(data, msb, pbit, k));
            if (gaps && k + 1 < nbits) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        sel        = 1'b0;
        ser_in     = 1'b0;
        ser_valid  = 1'b0;
        word_ready = 1'b1;
        rst        = 1'b1;

        repeat (2) @(negedge clk);
        for (int unsigned s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("reset_word_out",   word_out,          32'h0);
            check("reset_word_valid", {31'b0, word_valid}, 32'h0);
            check("reset_parity_err", {31'b0, parity_err}, 32'h0);
            check("reset_ser_ready",  {31'b0, ser_ready},  32'h1);
        end
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{1'b0, 32'hDEADBEEF, ^32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h12345678, ^32'h12345678, 1'b1, 32'h12345678, 1'b0});
        vecs.push_back('{1'b0, 32'h80000001, ^32'h80000001, 1'b1, 32'h80000001, 1'b0});
        vecs.push_back('{1'b1, 32'h80000000, ^32'h80000000, 1'b0, 32'h80000000, 1'b0});
        vecs.push_back('{1'b0, 32'h00000000, 1'b0,          1'b0, 32'h00000000, 1'b0});
        vecs.push_back('{1'b1, 32'hFFFFFFFF, 1'b0,          1'b1, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{1'b0, 32'h0000FFFE, ^32'h0000FFFE, 1'b0, 32'h0000FFFE, 1'b0});
`ifdef WORD_DESER_PARITY_EN
        vecs.push_back('{1'b0, 32'h00000003, 1'b0, 1'b0, 32'h00000003, 1'b0});
        vecs.push_back('{1'b0, 32'h00000007, 1'b0, 1'b0, 32'h00000007, 1'b1});
        vecs.push_back('{1'b1, 32'h00000007, 1'b1, 1'b1, 32'h00000007, 1'b0});
`endif

        word_ready = 1'b1;
        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            send_bits(vecs[i].data, !vecs[i].sel, vecs[i].pbit, vecs[i].gaps, FRAME);
            #1;
            check($sformatf("vec%0d_valid", i), {31'b0, word_valid}, 32'h1);
            check($sformatf("vec%0d_word", i), word_out, vecs[i].exp_word);
            check($sformatf("vec%0d_perr", i), {31'b0, parity_err}, {31'b0, vecs[i].exp_perr});
            @(negedge clk);
            #1;
            check($sformatf("vec%0d_drained", i), {31'b0, word_valid}, 32'h0);
        end

        // Backpressure: word 1 held, completing bit of frame 2 stalls until word_ready.
        sel        = 1'b0;
        word_ready = 1'b0;
        send_bits(32'hAAAA5555, 1'b1, ^32'hAAAA5555, 1'b0, FRAME);
        #1;
        check("bp_w1_valid", {31'b0, word_valid}, 32'h1);
        check("bp_w1_word",  word_out, 32'hAAAA5555);
        send_bits(32'h0F0F0F0F, 1'b1, ^32'h0F0F0F0F, 1'b0, FRAME - 1);
        ser_in    = frame_bit(32'h0F0F0F0F, 1'b1, ^32'h0F0F0F0F, FRAME - 1);
        ser_valid = 1'b1;
        #1;
        check("bp_stall_ready", {31'b0, ser_ready}, 32'h0);
        @(negedge clk);
        #1;
        check("bp_stall_ready2", {31'b0, ser_ready}, 32'h0);
        check("bp_hold_word",   word_out, 32'hAAAA5555);
        check("bp_hold_valid",  {31'b0, word_valid}, 32'h1);
        word_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'b0, ser_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        ser_valid  = 1'b0;
        word_ready = 1'b0;
        #1;
        check("bp_w2_valid", {31'b0, word_valid}, 32'h1);
        check("bp_w2_word",  word_out, 32'h0F0F0F0F);
        word_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_w2_drained", {31'b0, word_valid}, 32'h0);

        // Reset mid-frame: 17 bits discarded, then a clean frame.
        sel = 1'b1;
        send_bits(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 17);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rmf_valid", {31'b0, word_valid}, 32'h0);
        check("rmf_ready", {31'b0, ser_ready}, 32'h1);
        send_bits(32'h00000001, 1'b0, 1'b1, 1'b0, FRAME);
        #1;
        check("rmf_word_valid", {31'b0, word_valid}, 32'h1);
        check("rmf_word", word_out, 32'h00000001);
        @(negedge clk);

        // Reset for 2 cycles while a word is held and a frame is partial.
        sel        = 1'b0;
        word_ready = 1'b0;
        send_bits(32'hC0FFEE11, 1'b1, ^32'hC0FFEE11, 1'b0, FRAME);
        send_bits(32'h12345678, 1'b1, 1'b0, 1'b0, 5);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rmh_word_out",   word_out, 32'h0);
        check("rmh_word_valid", {31'b0, word_valid}, 32'h0);
        check("rmh_parity_err", {31'b0, parity_err}, 32'h0);
        check("rmh_ser_ready",  {31'b0, ser_ready}, 32'h1);
        rst        = 1'b0;
        word_ready = 1'b1;
        @(negedge clk);
        send_bits(32'h5A5AA5A5, 1'b1, ^32'h5A5AA5A5, 1'b0, FRAME);
        #1;
        check("rmh_after_word", word_out, 32'h5A5AA5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
